// File: rtl/mem_access_stage.sv
// DLX MEM stage: drives loads and stores over a req/ack data-memory port.
// It steers store bytes onto their lanes, formats load data, checks alignment,
// and holds stall while an access is outstanding. It presents either a bubble
// or a completed instruction to MEM/WB on every cycle.
module mem_access_stage #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_in,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] lmd_out,
   output logic [31:0] aluoutput_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        stall,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       lmd_q, lmd_d;
   logic              aborted_q, aborted_d;
   logic              req_q, req_d, we_q, we_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              mis_q, mis_d, bus_q, bus_d;

   logic              mem_op, is_word, is_half, illegal, mem_go, timeout_hit;
   logic [3:0]        be_new;
   logic [31:0]       wdata_new, load_fmt;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   // Decode, alignment check, store lane steering and load formatting
   always_comb begin
      mem_op      = mem_read | mem_write;
      is_word     = mem_size[1];
      is_half     = (mem_size == 2'b01);
      illegal     = mem_op & ((mem_read & mem_write) |
                              (is_half & alu_result[0]) |
                              (is_word & (|alu_result[1:0])));
      mem_go      = in_valid & mem_op & ~illegal;
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
      be_new      = 4'b1111;
      wdata_new   = store_data;
      if (is_half) begin
         be_new    = alu_result[1] ? 4'b1100 : 4'b0011;
         wdata_new = {2{store_data[15:0]}};
      end else if (!is_word) begin
         be_new    = 4'b0001 << alu_result[1:0];
         wdata_new = {4{store_data[7:0]}};
      end
      byte_sel = dmem_rdata[8*alu_result[1:0] +: 8];
      half_sel = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_fmt = dmem_rdata;
      if (is_half)
         load_fmt = {{16{~mem_unsigned & half_sel[15]}}, half_sel};
      else if (!is_word)
         load_fmt = {{24{~mem_unsigned & byte_sel[7]}}, byte_sel};
   end

   // State and datapath registers; reset also drops dmem_req at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lmd_q     <= '0;
         aborted_q <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         mis_q     <= 1'b0;
         bus_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lmd_q     <= lmd_d;
         aborted_q <= aborted_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         mis_q     <= mis_d;
         bus_q     <= bus_d;
      end
   end

   // Next state: issue, wait for ack or timeout, then one completion cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lmd_d     = lmd_q;
      aborted_d = aborted_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      mis_d     = 1'b0;
      bus_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_go) begin
               state_d   = ACCESS;
               cnt_d     = '0;
               aborted_d = 1'b0;
               req_d     = 1'b1;
               we_d      = mem_write;
               addr_d    = {alu_result[31:2], 2'b00};
               wdata_d   = wdata_new;
               be_d      = be_new;
            end
            mis_d = in_valid & illegal;
         end
         ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem_ack) begin
               // An ack arriving on the timeout cycle still completes normally
               state_d = DONE;
               req_d   = 1'b0;
               if (mem_read) lmd_d = load_fmt;
            end else if (timeout_hit) begin
               state_d   = DONE;
               req_d     = 1'b0;
               bus_d     = 1'b1;
               lmd_d     = '0;
               aborted_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: bubble unless a non-memory op passes through or an access completes
   always_comb begin
      lmd_out        = '0;
      aluoutput_out  = '0;
      rd_out         = '0;
      reg_write_out  = 1'b0;
      mem_to_reg_out = 1'b0;
      stall          = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall = mem_go;
            if (in_valid && !mem_op) begin
               aluoutput_out  = alu_result;
               rd_out         = rd_in;
               reg_write_out  = reg_write_in;
               mem_to_reg_out = mem_to_reg_in;
            end
         end
         ACCESS: stall = 1'b1;
         DONE: begin
            lmd_out        = lmd_q;
            aluoutput_out  = alu_result;
            rd_out         = rd_in;
            reg_write_out  = reg_write_in & ~aborted_q;
            mem_to_reg_out = mem_to_reg_in;
         end
         default: ;
      endcase
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_be      = be_q;
   assign misalign_err = mis_q;
   assign bus_err      = bus_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed vectors and
// pushes the expected MEM/WB record, a monitor pops and compares whenever the
// stage completes an instruction, and a memory responder acks after a set delay.
module tb_mem_access_stage;

   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] alu_result = '0, store_data = '0;
   logic [4:0]  rd_in = '0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [1:0]  mem_size = '0;
   logic        mem_unsigned = 1'b0, reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic [31:0] lmd_out, aluoutput_out;
   logic [4:0]  rd_out;
   logic        reg_write_out, mem_to_reg_out, stall, misalign_err, bus_err;

   mem_access_stage #(.TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
      .store_data(store_data), .rd_in(rd_in), .mem_read(mem_read),
      .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .lmd_out(lmd_out), .aluoutput_out(aluoutput_out),
      .rd_out(rd_out), .reg_write_out(reg_write_out),
      .mem_to_reg_out(mem_to_reg_out), .stall(stall),
      .misalign_err(misalign_err), .bus_err(bus_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lmd;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
   } rec_t;

   typedef struct {
      logic [31:0] alu; logic [31:0] sd; logic [4:0] rd;
      logic rdv; logic wrv; logic [1:0] size; logic uns; logic rw; logic m2r;
      int delay; logic [31:0] rdata;
      logic [3:0] exp_be; logic [31:0] exp_wd; logic [31:0] exp_lmd; logic exp_rw;
      logic ill; int exp_stall; int exp_req; int exp_mis; int exp_bus;
   } vec_t;

   rec_t        sb[$];
   int          checks = 0, errors = 0;
   int          ack_delay = -1;  // ACCESS cycle index (0 = first) that gets the ack
   logic        ack_force = 1'b0;
   logic [31:0] rdata_v = '0;
   logic [3:0]  exp_be_v = '0;
   logic [31:0] exp_wd_v = '0, exp_addr_v = '0;
   logic        exp_we_v = 1'b0;
   int          req_total = 0, mis_total = 0, bus_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: acks on the chosen ACCESS cycle and checks the request
   int req_cyc = 0;
   always @(negedge clk) begin
      if (dmem_req) begin
         req_cyc++;
         req_total++;
         if (req_cyc == 1) begin
            chk("dmem_addr", dmem_addr, exp_addr_v);
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be_v});
            chk("dmem_wdata", dmem_wdata, exp_wd_v);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we_v});
         end
         dmem_ack   = ack_force || (ack_delay >= 0 && req_cyc == ack_delay + 1);
         dmem_rdata = rdata_v;
      end else begin
         req_cyc  = 0;
         dmem_ack = ack_force;
      end
      if (misalign_err) mis_total++;
      if (bus_err)      bus_total++;
   end

   // Monitor: every completing cycle pops a record, every other cycle must be a bubble
   always @(negedge clk) begin
      rec_t e;
      if (in_valid && !stall) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: output with no expected record");
         end else begin
            e = sb.pop_front();
            chk("lmd_out", lmd_out, e.lmd);
            chk("aluoutput_out", aluoutput_out, e.alu);
            chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
            chk("mem_to_reg_out", {31'd0, mem_to_reg_out}, {31'd0, e.m2r});
         end
      end else if (!reset) begin
         chk("bubble", {lmd_out | aluoutput_out}, 32'd0);
         chk("bubble_ctl", {29'd0, rd_out != 5'd0, reg_write_out, mem_to_reg_out}, 32'd0);
      end
   end

   task automatic run_vec(input vec_t v);
      rec_t e;
      int s0, m0, b0, stall_n;
      bit done;
      @(posedge clk); #1;
      alu_result = v.alu; store_data = v.sd; rd_in = v.rd; mem_read = v.rdv;
      mem_write = v.wrv; mem_size = v.size; mem_unsigned = v.uns;
      reg_write_in = v.rw; mem_to_reg_in = v.m2r;
      ack_delay = v.delay; rdata_v = v.rdata;
      exp_be_v = v.exp_be; exp_wd_v = v.exp_wd; exp_we_v = v.wrv;
      exp_addr_v = {v.alu[31:2], 2'b00};
      if (v.ill) e = '{lmd: '0, alu: '0, rd: '0, rw: 1'b0, m2r: 1'b0};
      else       e = '{lmd: v.exp_lmd, alu: v.alu, rd: v.rd, rw: v.exp_rw, m2r: v.m2r};
      sb.push_back(e);
      s0 = req_total; m0 = mis_total; b0 = bus_total;
      in_valid = 1'b1;
      stall_n = 0; done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (stall) stall_n++; else done = 1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL completion_timeout: stall still high after 64 cycles");
      end
      chk("stall_cycles", stall_n, v.exp_stall);
      @(posedge clk); #1;
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ack_delay = -1;
      repeat (2) @(negedge clk);
      chk("req_cycles", req_total - s0, v.exp_req);
      chk("misalign_pulses", mis_total - m0, v.exp_mis);
      chk("bus_err_pulses", bus_total - b0, v.exp_bus);
   endtask

   vec_t vecs[14];

   initial begin
      //          alu          sd           rd  rd wr size uns rw m2r dly rdata        be       wdata        lmd          rw ill stl req mis bus
      vecs[0]  = '{32'h1234,   32'h0,       7,  0, 0, 2'b10, 0, 1, 0, -1, 32'h0,       4'b0000, 32'h0,       32'h0,       1, 0, 0,  0,  0, 0};
      vecs[1]  = '{32'h103,    32'hAABBCCDD,3,  0, 1, 2'b00, 0, 0, 0,  0, 32'h0,       4'b1000, 32'hDDDDDDDD,32'h0,       0, 0, 2,  1,  0, 0};
      vecs[2]  = '{32'h202,    32'h0,       5,  1, 0, 2'b01, 0, 1, 1,  2, 32'h80010000,4'b1100, 32'h0,       32'hFFFF8001,1, 0, 4,  3,  0, 0};
      vecs[3]  = '{32'h202,    32'h0,       6,  1, 0, 2'b01, 1, 1, 1,  0, 32'h80010000,4'b1100, 32'h0,       32'h00008001,1, 0, 2,  1,  0, 0};
      vecs[4]  = '{32'h005,    32'h0,       9,  1, 0, 2'b10, 0, 1, 1, -1, 32'h0,       4'b0000, 32'h0,       32'h0,       0, 1, 0,  0,  1, 0};
      vecs[5]  = '{32'h001,    32'h0,       10, 1, 0, 2'b00, 0, 1, 1,  1, 32'h1234A678,4'b0010, 32'h0,       32'hFFFFFFA6,1, 0, 3,  2,  0, 0};
      vecs[6]  = '{32'h003,    32'h0,       11, 1, 0, 2'b00, 1, 1, 1,  0, 32'h9ABCDEF0,4'b1000, 32'h0,       32'h0000009A,1, 0, 2,  1,  0, 0};
      vecs[7]  = '{32'h300,    32'hCAFEBABE,0,  0, 1, 2'b10, 0, 0, 0,  0, 32'h0,       4'b1111, 32'hCAFEBABE,32'h0000009A,0, 0, 2,  1,  0, 0};
      vecs[8]  = '{32'h206,    32'h1234ABCD,0,  0, 1, 2'b01, 0, 0, 0,  1, 32'h0,       4'b1100, 32'hABCDABCD,32'h0000009A,0, 0, 3,  2,  0, 0};
      vecs[9]  = '{32'h207,    32'h1234ABCD,0,  0, 1, 2'b01, 0, 0, 0, -1, 32'h0,       4'b0000, 32'h0,       32'h0,       0, 1, 0,  0,  1, 0};
      vecs[10] = '{32'h010,    32'h0,       4,  1, 1, 2'b10, 0, 1, 1, -1, 32'h0,       4'b0000, 32'h0,       32'h0,       0, 1, 0,  0,  1, 0};
      vecs[11] = '{32'h400,    32'h0,       12, 1, 0, 2'b11, 0, 1, 1,  0, 32'h89ABCDEF,4'b1111, 32'h0,       32'h89ABCDEF,1, 0, 2,  1,  0, 0};
      vecs[12] = '{32'h500,    32'h0,       13, 1, 0, 2'b10, 0, 1, 1, -1, 32'h0,       4'b1111, 32'h0,       32'h0,       0, 0, 16, 15, 0, 1};
      vecs[13] = '{32'hDEAD,   32'h0,       31, 0, 0, 2'b00, 0, 1, 0, -1, 32'h0,       4'b0000, 32'h0,       32'h0,       1, 0, 0,  0,  0, 0};

      // Reset state
      @(negedge clk);
      chk("reset_req", {31'd0, dmem_req}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_errs", {30'd0, misalign_err, bus_err}, 32'd0);
      chk("reset_be_addr", {28'd0, dmem_be} | dmem_addr | dmem_wdata, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset in the middle of an access, then a stray ack after release
      @(posedge clk); #1;
      alu_result = 32'h600; mem_read = 1'b1; mem_size = 2'b10; rd_in = 5'd3;
      reg_write_in = 1'b1; ack_delay = -1;
      exp_addr_v = 32'h600; exp_be_v = 4'b1111; exp_wd_v = store_data; exp_we_v = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_reset_req", {31'd0, dmem_req}, 32'd1);
      #2; reset = 1'b1; in_valid = 1'b0;
      #1;
      chk("async_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("reset_mid_stall", {31'd0, stall}, 32'd0);
      chk("reset_mid_addr", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'd0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); ack_force = 1'b1;
      @(negedge clk); ack_force = 1'b0;
      chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
      chk("late_ack_stall", {31'd0, stall}, 32'd0);
      chk("late_ack_errs", {30'd0, misalign_err, bus_err}, 32'd0);
      run_vec(vecs[13]);

      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- DLX MEM stage. Sits between the EX/MEM pipeline registers and the MEM/WB pipeline registers.
- Performs loads and stores through a req/ack data-memory handshake, and handles byte-lane steering, load sign/zero extension and alignment checks.
- Asserts stall so upstream stages freeze while an access is outstanding.
- Drives the MEM/WB inputs: lmd, aluoutput, rd, register-write enable, mem_to_reg.

Parameters:
- TIMEOUT, 15: ACCESS-state cycles without dmem_ack before the access is aborted with a bus error.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- alu_result  in  32  effective address, or ALU result for non-memory ops
- store_data  in  32  store source register value
- rd_in  in  5  destination register
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 or 11 word
- mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- reg_write_in  in  1  instruction writes the register file
- mem_to_reg_in  in  1  write-back selects lmd
- dmem_req  out  1  registered memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, alu_result with [1:0] forced to 00
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables, little-endian
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  access complete, single-cycle pulse
- lmd_out  out  32  formatted load data to MEM/WB
- aluoutput_out  out  32  alu_result pass-through to MEM/WB
- rd_out  out  5  to MEM/WB
- reg_write_out  out  1  to MEM/WB register-write-enable input
- mem_to_reg_out  out  1  to MEM/WB
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign_err  out  1  one-cycle registered pulse
- bus_err  out  1  one-cycle registered pulse

Behaviour:
- Reset: clk; reset is asynchronous, active-high. It forces:
  - state IDLE, counter 0, lmd register 0;
  - dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, dmem_be 0000;
  - misalign_err and bus_err 0.
  - Combinational outputs follow from IDLE with the current inputs.
- Bubble: reg_write_out=0, mem_to_reg_out=0, rd_out=0, lmd_out=0, aluoutput_out=0. MEM/WB captures every clock, so every non-completing cycle must present a bubble.
- IDLE:
  - in_valid=0: bubble, stall=0.
  - Valid non-memory op: pass-through in the same cycle (aluoutput_out=alu_result, rd_out, reg_write_out, mem_to_reg_out from inputs), lmd_out=0, stall=0.
  - Valid memory op, legal and aligned: stall=1, bubble. Latch dmem_we, dmem_addr, dmem_wdata and dmem_be, set dmem_req=1, clear the counter, go to ACCESS.
  - Illegal op: bubble, stall=0, misalign_err pulses next cycle, no memory access, state stays IDLE. Illegal means any of:
    - half access with alu_result[0]=1;
    - word access with alu_result[1:0]≠00;
    - mem_read and mem_write both 1.
- ACCESS:
  - stall=1, bubble.
  - dmem_req and all dmem_* outputs held stable.
  - Counter increments each cycle.
  - dmem_ack=1: drop dmem_req next edge. For loads, capture formatted dmem_rdata into the lmd register. Go to DONE.
  - Counter reaches TIMEOUT with no ack: drop dmem_req, bus_err pulses, lmd register cleared, completion flagged aborted, go to DONE.
  - An ack in the same cycle the counter reaches TIMEOUT wins, so no bus_err.
- DONE:
  - stall=0. EX/MEM inputs are still held by the freeze.
  - Present lmd_out=lmd register, aluoutput_out=alu_result, rd_out, mem_to_reg_out.
  - reg_write_out=reg_write_in, except 0 if the access was aborted.
  - Next edge goes to IDLE.
  - Minimum memory-op latency: 2 stall cycles (request issued, ack in the first ACCESS cycle).
- Store steering:
  - Byte: dmem_be = 0001 << addr[1:0]; wdata = store_data[7:0] replicated ×4.
  - Half: be = addr[1] ? 1100 : 0011; wdata = store_data[15:0] replicated ×2.
  - Word: be=1111; wdata = store_data.
  - Loads use the same be pattern with dmem_we=0.
- Load formatting:
  - Select byte lane addr[1:0] or half lane addr[1] from dmem_rdata.
  - Sign- or zero-extend to 32 bits per mem_unsigned. Word loads are unchanged.
- dmem_ack is ignored outside ACCESS.
- Reset asserted during ACCESS: dmem_req drops immediately (asynchronously), the access is abandoned, and a late ack is ignored.

Test Plan:
- Non-memory op: in_valid=1, alu_result=0x0000_1234, rd=7, reg_write=1 → same cycle aluoutput_out=0x1234, rd_out=7, reg_write_out=1, stall=0, dmem_req never asserted.
- Byte store: addr=0x103, store_data=0xAABBCCDD, ack on first ACCESS cycle → dmem_be=1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x100, stall high exactly 2 cycles, reg_write_out=0 in DONE.
- Signed half load: addr=0x202, rdata=0x8001_0000 → lmd_out=0xFFFF_8001; same with mem_unsigned=1 → 0x0000_8001. Ack delayed 3 cycles → stall high 4 cycles.
- Misaligned word load: addr=0x005 → misalign_err high one cycle, no dmem_req, stall=0, reg_write_out=0.
- Timeout: TIMEOUT=15, never ack → dmem_req high 15 cycles, bus_err one pulse, DONE with reg_write_out=0, lmd_out=0, then IDLE.
- Reset mid-ACCESS, followed by ack one cycle after reset release → dmem_req=0 immediately, all outputs at reset values, ack ignored, stall=0.
